// File: rtl/ahb_master_interface.sv
// AHB-Lite initiator for the AHB-to-APB bridge window: turns local SINGLE/INCR4
// word commands into pipelined AHB address/data phases with wait and ERROR handling.
module ahb_master_interface #(
  parameter logic [31:0] ADDR_LO = 32'h8000_0000,
  parameter logic [31:0] ADDR_HI = 32'h8C00_0000
) (
  input  logic         Hclk,
  input  logic         Hreset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_write,
  input  logic         cmd_burst,
  input  logic [31:0]  cmd_addr,
  input  logic [127:0] cmd_wdata,
  output logic [1:0]   Htrans,
  output logic [31:0]  Haddr,
  output logic         Hwrite,
  output logic [2:0]   Hsize,
  output logic [2:0]   Hburst,
  output logic [31:0]  Hwdata,
  input  logic         Hreadyout,
  input  logic [1:0]   Hresp,
  input  logic [31:0]  Hrdata,
  output logic         rd_valid,
  output logic [31:0]  rd_data,
  output logic         rd_last,
  output logic         done,
  output logic         err,
  output logic [2:0]   o_dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_PIPE, S_DATA, S_RESP} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  state_t       r_state;
  logic         r_cmd_ready;
  logic [1:0]   r_htrans;
  logic [31:0]  r_haddr;
  logic         r_hwrite;
  logic [2:0]   r_hburst;
  logic [31:0]  r_hwdata;
  logic         r_rd_valid;
  logic [31:0]  r_rd_data;
  logic         r_rd_last;
  logic         r_done;
  logic         r_err;
  logic         r_burst;
  logic [127:0] r_wdata;
  logic [1:0]   r_beat;
  logic         r_err_seen;
  logic         r_rejected;

  logic [31:0]  w_addr;
  logic         w_reject;
  logic         w_accept;
  logic         w_resp_err;

  // Command handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is only ever high while the block is idle.
  assign w_addr     = cmd_addr & 32'hFFFF_FFFC;
  assign w_reject   = (w_addr < ADDR_LO) || (w_addr >= ADDR_HI) ||
                      (cmd_burst && (w_addr[9:0] > 10'h3F0));
  assign w_accept   = cmd_valid && r_cmd_ready;
  assign w_resp_err = (Hresp != 2'b00);

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_htrans    <= TR_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hburst    <= 3'b000;
      r_hwdata    <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_rd_last   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_burst     <= 1'b0;
      r_wdata     <= '0;
      r_beat      <= 2'd0;
      r_err_seen  <= 1'b0;
      r_rejected  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_htrans    <= TR_IDLE;
          r_cmd_ready <= 1'b1;
          r_err_seen  <= 1'b0;
          if (w_accept) begin
            r_cmd_ready <= 1'b0;
            r_burst     <= cmd_burst;
            r_wdata     <= cmd_wdata;
            if (w_reject) begin
              r_state    <= S_RESP;
              r_rejected <= 1'b1;
            end else begin
              r_state  <= S_ADDR;
              r_htrans <= TR_NONSEQ;
              r_haddr  <= w_addr;
              r_hwrite <= cmd_write;
              r_hburst <= cmd_burst ? 3'b011 : 3'b000;
            end
          end
        end
        S_ADDR: begin
          if (Hreadyout) begin
            r_hwdata <= r_wdata[31:0];
            if (r_burst) begin
              r_state  <= S_PIPE;
              r_beat   <= 2'd1;
              r_htrans <= TR_SEQ;
              r_haddr  <= r_haddr + 32'd4;
            end else begin
              r_state  <= S_DATA;
              r_htrans <= TR_IDLE;
            end
          end
        end
        S_PIPE: begin
          if (w_resp_err && !Hreadyout) begin
            // First ERROR cycle: withdraw the pending SEQ, finish in DATA.
            r_htrans   <= TR_IDLE;
            r_err_seen <= 1'b1;
            r_state    <= S_DATA;
          end else if (Hreadyout) begin
            if (w_resp_err) begin
              r_htrans <= TR_IDLE;
              r_state  <= S_RESP;
              r_done   <= 1'b1;
              r_err    <= 1'b1;
            end else begin
              if (!r_hwrite) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= Hrdata;
              end
              r_hwdata <= r_wdata[{r_beat, 5'd0} +: 32];
              if (r_beat == 2'd3) begin
                r_state  <= S_DATA;
                r_htrans <= TR_IDLE;
              end else begin
                r_beat  <= r_beat + 2'd1;
                r_haddr <= r_haddr + 32'd4;
              end
            end
          end
        end
        S_DATA: begin
          r_htrans <= TR_IDLE;
          if (Hreadyout) begin
            r_state <= S_RESP;
            r_done  <= 1'b1;
            if (w_resp_err || r_err_seen) begin
              r_err <= 1'b1;
            end else if (!r_hwrite) begin
              r_rd_valid <= 1'b1;
              r_rd_data  <= Hrdata;
              r_rd_last  <= 1'b1;
            end
          end
        end
        S_RESP: begin
          // A rejected command spends one extra RESP cycle before its done pulse.
          if (r_rejected) begin
            r_rejected <= 1'b0;
            r_done     <= 1'b1;
            r_err      <= 1'b1;
          end else begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign Htrans      = r_htrans;
  assign Haddr       = r_haddr;
  assign Hwrite      = r_hwrite;
  assign Hsize       = 3'b010;
  assign Hburst      = r_hburst;
  assign Hwdata      = r_hwdata;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign rd_last     = r_rd_last;
  assign done        = r_done;
  assign err         = r_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ahb_master_interface.sv
// Bench for ahb_master_interface: a behavioural AHB slave plus a command-level
// model predicting accepted addresses, write/read beats, completion status and latency.
module tb_ahb_master_interface;

  localparam logic [31:0] LO = 32'h8000_0000;
  localparam logic [31:0] HI = 32'h8C00_0000;

  logic         Hclk = 1'b0;
  logic         Hreset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic         cmd_burst;
  logic [31:0]  cmd_addr;
  logic [127:0] cmd_wdata;
  logic [1:0]   Htrans;
  logic [31:0]  Haddr;
  logic         Hwrite;
  logic [2:0]   Hsize;
  logic [2:0]   Hburst;
  logic [31:0]  Hwdata;
  logic         Hreadyout;
  logic [1:0]   Hresp;
  logic [31:0]  Hrdata;
  logic         rd_valid;
  logic [31:0]  rd_data;
  logic         rd_last;
  logic         done;
  logic         err;
  logic [2:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] exp_q[$];

  ahb_master_interface dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_burst(cmd_burst), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .Htrans(Htrans), .Haddr(Haddr), .Hwrite(Hwrite), .Hsize(Hsize),
    .Hburst(Hburst), .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
    .Hrdata(Hrdata), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err), .o_dbg_state(dbg_state)
  );

  always #5 Hclk = ~Hclk;

  // A 16-byte burst must stay inside its 1 KB page; the window is [LO, HI).
  function automatic logic model_reject(input logic burst, input logic [31:0] addr);
    logic [31:0] a;
    a = addr & 32'hFFFF_FFFC;
    return (a < LO) || (a >= HI) || (burst && ((a % 1024) + 16 > 1024));
  endfunction

  task automatic run_cmd(input string name, input logic wr, input logic burst,
                         input logic [31:0] addr, input logic [127:0] wdata,
                         input logic [127:0] rdata, input logic [15:0] waits,
                         input int addr_wait, input int err_beat, output int done_cyc);
    int nbeats, acc, beat, wleft, estage, aleft, exp_acc, exp_cyc, nw;
    logic rej, dph, exp_err, chk_idle_next, hold_chk;
    logic [31:0] base, hold_addr;
    logic [1:0] hold_trans;
    logic [32:0] e;
    nbeats  = burst ? 4 : 1;
    rej     = model_reject(burst, addr);
    base    = addr & 32'hFFFF_FFFC;
    exp_err = rej || (err_beat != 0);
    exp_acc = rej ? 0 : ((err_beat != 0) ? err_beat : nbeats);
    nw      = (err_beat != 0) ? err_beat - 1 : nbeats;
    exp_cyc = 2 + addr_wait + exp_acc + ((err_beat != 0) ? 1 : 0);
    for (int i = 0; i < nw; i++) exp_cyc += int'(waits[4*i +: 4]);
    if (rej) exp_cyc = 2;
    acc = 0; dph = 1'b0; beat = 0; wleft = 0; estage = 0; aleft = addr_wait;
    chk_idle_next = 1'b0; hold_chk = 1'b0; done_cyc = -1;
    hold_addr = '0; hold_trans = '0;
    @(negedge Hclk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s/ready_before_accept: got %b expected 1", name, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_burst = burst; cmd_addr = addr; cmd_wdata = wdata;
    Hreadyout = 1'b1; Hresp = 2'b00;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge Hclk);
      cmd_valid = 1'b0;
      n_checks++;
      if (Hsize !== 3'b010) begin
        n_fail++; $display("FAIL %s/hsize: got %b expected 010", name, Hsize);
      end
      if (rd_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s/rd_unexpected: got data %h expected no rd_valid", name, rd_data);
        end else begin
          e = exp_q.pop_front();
          if ({rd_last, rd_data} !== e) begin
            n_fail++; $display("FAIL %s/rd_beat: got last=%b data=%h expected last=%b data=%h",
                               name, rd_last, rd_data, e[32], e[31:0]);
          end
        end
      end
      if (chk_idle_next) begin
        n_checks++; chk_idle_next = 1'b0;
        if (Htrans !== 2'b00) begin
          n_fail++; $display("FAIL %s/htrans_after_error: got %b expected 00", name, Htrans);
        end
      end
      if (hold_chk) begin
        n_checks++; hold_chk = 1'b0;
        if ({Htrans, Haddr} !== {hold_trans, hold_addr}) begin
          n_fail++; $display("FAIL %s/addr_hold: got %b %h expected %b %h",
                             name, Htrans, Haddr, hold_trans, hold_addr);
        end
      end
      if (rej) begin
        n_checks++;
        if (Htrans !== 2'b00) begin
          n_fail++; $display("FAIL %s/reject_bus_idle: got %b expected 00", name, Htrans);
        end
      end
      if (done === 1'b1) begin
        done_cyc = cyc;
        n_checks++;
        if (err !== exp_err) begin
          n_fail++; $display("FAIL %s/err: got %b expected %b", name, err, exp_err);
        end
        n_checks++;
        if (acc != exp_acc) begin
          n_fail++; $display("FAIL %s/beats_issued: got %0d expected %0d", name, acc, exp_acc);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
          n_fail++; $display("FAIL %s/rd_missing: got %0d pending expected 0", name, exp_q.size());
        end
        n_checks++;
        if (cyc != exp_cyc) begin
          n_fail++; $display("FAIL %s/latency: got %0d expected %0d", name, cyc, exp_cyc);
        end
        exp_q.delete();
        break;
      end
      // Slave response for this cycle; Hresp is noise outside data phases.
      Hrdata = $urandom();
      Hresp = {1'b0, 1'($urandom_range(0, 1))};
      Hreadyout = 1'b1;
      if (dph) begin
        if (err_beat == beat + 1) begin
          Hresp = 2'b01;
          Hreadyout = (estage == 1);
          if (estage == 0) chk_idle_next = 1'b1;
          estage++;
        end else if (wleft > 0) begin
          Hreadyout = 1'b0; Hresp = 2'b00; wleft--;
        end else begin
          Hresp = 2'b00; Hrdata = rdata[32*beat +: 32];
        end
      end else if (aleft > 0 && Htrans != 2'b00) begin
        Hreadyout = 1'b0; aleft--;
      end
      if (Hreadyout) begin
        if (dph && Hresp == 2'b00) begin
          if (wr) begin
            n_checks++;
            if (Hwdata !== wdata[32*beat +: 32]) begin
              n_fail++; $display("FAIL %s/hwdata_beat%0d: got %h expected %h",
                                 name, beat, Hwdata, wdata[32*beat +: 32]);
            end
          end else begin
            exp_q.push_back({(beat == nbeats - 1) ? 1'b1 : 1'b0, Hrdata});
          end
        end
        dph = 1'b0;
        if (Htrans[1] === 1'b1) begin
          n_checks++;
          if (acc >= exp_acc || Haddr !== base + 32'(4 * acc) ||
              Htrans !== ((acc == 0) ? 2'b10 : 2'b11) || Hwrite !== wr ||
              Hburst !== (burst ? 3'b011 : 3'b000)) begin
            n_fail++; $display("FAIL %s/addr_phase%0d: got trans=%b addr=%h wr=%b burst=%b expected addr=%h of %0d beats",
                               name, acc, Htrans, Haddr, Hwrite, Hburst, base + 32'(4 * acc), exp_acc);
          end
          beat = acc; acc++; dph = 1'b1;
          wleft = int'(waits[4*beat +: 4]);
        end
      end else if (Htrans[1] === 1'b1 && estage == 0) begin
        hold_chk = 1'b1; hold_trans = Htrans; hold_addr = Haddr;
      end
    end
    if (done_cyc < 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s/timeout: got no done in 200 cycles (state %0d) expected done", name, dbg_state);
    end
    @(negedge Hclk);
    Hreadyout = 1'b1; Hresp = 2'b00;
    n_checks++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s/after_done: got done=%b ready=%b expected 0 1", name, done, cmd_ready);
    end
  endtask

  task automatic test_reset();
    Hreset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_burst = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; Hreadyout = 1'b1; Hresp = 2'b00; Hrdata = '0;
    repeat (3) @(negedge Hclk);
    n_checks++;
    if ({Htrans, Haddr, Hwrite, Hburst, Hwdata, rd_valid, rd_data, rd_last, done, err, cmd_ready} !== '0) begin
      n_fail++; $display("FAIL reset/outputs: got trans=%b addr=%h wdata=%h ready=%b done=%b expected all 0",
                         Htrans, Haddr, Hwdata, cmd_ready, done);
    end
    n_checks++;
    if (Hsize !== 3'b010) begin
      n_fail++; $display("FAIL reset/hsize: got %b expected 010", Hsize);
    end
    Hreset = 1'b0;
    @(negedge Hclk);
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset/ready_after_release: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single_write();
    int dc;
    run_cmd("single_wr", 1'b1, 1'b0, 32'h8000_0010, {96'h0, 32'hDEADBEEF},
            {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0, 0, 0, dc);
  endtask

  task automatic test_incr4_read_waits();
    int dc;
    run_cmd("incr4_rd_wait", 1'b0, 1'b1, 32'h8400_0000, '0,
            {32'h44, 32'h33, 32'h22, 32'h11}, 16'h0020, 0, 0, dc);
  endtask

  task automatic test_error();
    int dc;
    run_cmd("incr4_wr_err", 1'b1, 1'b1, 32'h8800_0000,
            {$urandom(), $urandom(), $urandom(), $urandom()}, '0, 16'h0, 0, 2, dc);
    run_cmd("single_rd_err", 1'b0, 1'b0, 32'h8000_0040, '0, '0, 16'h0, 1, 1, dc);
  endtask

  task automatic test_boundaries();
    int dc;
    run_cmd("rej_high", 1'b0, 1'b0, 32'h9000_0000, '0, '0, 16'h0, 0, 0, dc);
    run_cmd("rej_page", 1'b1, 1'b1, 32'h8000_03F8, 128'h1, '0, 16'h0, 0, 0, dc);
    run_cmd("ok_page_edge", 1'b0, 1'b1, 32'h8000_03F0, '0,
            {$urandom(), $urandom(), $urandom(), $urandom()}, 16'h0, 0, 0, dc);
    run_cmd("rej_page_3f4", 1'b0, 1'b1, 32'h8000_03F4, '0, '0, 16'h0, 0, 0, dc);
    run_cmd("rej_below", 1'b1, 1'b0, 32'h7FFF_FFFC, 128'h5, '0, 16'h0, 0, 0, dc);
    run_cmd("ok_top_word", 1'b1, 1'b0, 32'h8BFF_FFFF, 128'hCAFE, '0, 16'h0, 1, 0, dc);
    run_cmd("rej_at_hi", 1'b0, 1'b0, 32'h8C00_0000, '0, '0, 16'h0, 0, 0, dc);
    run_cmd("ok_unaligned", 1'b0, 1'b0, 32'h8000_0013, '0, 128'h1234_5678, 16'h0, 0, 0, dc);
  endtask

  task automatic test_mid_reset();
    @(negedge Hclk);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_burst = 1'b1; cmd_addr = 32'h8000_0100;
    cmd_wdata = {$urandom(), $urandom(), $urandom(), $urandom()};
    Hreadyout = 1'b1; Hresp = 2'b00;
    @(negedge Hclk);
    cmd_valid = 1'b0;
    n_checks++;
    if (Htrans !== 2'b10) begin
      n_fail++; $display("FAIL mid_reset/nonseq: got %b expected 10", Htrans);
    end
    @(negedge Hclk);
    n_checks++;
    if (Htrans !== 2'b11) begin
      n_fail++; $display("FAIL mid_reset/seq: got %b expected 11", Htrans);
    end
    Hreset = 1'b1;
    @(negedge Hclk);
    n_checks++;
    if ({Htrans, Haddr, Hwdata, done, cmd_ready} !== '0) begin
      n_fail++; $display("FAIL mid_reset/cleared: got trans=%b addr=%h wdata=%h done=%b ready=%b expected all 0",
                         Htrans, Haddr, Hwdata, done, cmd_ready);
    end
    Hreset = 1'b0;
    @(negedge Hclk);
    n_checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset/ready: got ready=%b done=%b expected 1 0", cmd_ready, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge Hclk);
      n_checks++;
      if (done !== 1'b0 || Htrans !== 2'b00) begin
        n_fail++; $display("FAIL mid_reset/no_done: got done=%b trans=%b expected 0 00", done, Htrans);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, a2, d1, d2;
    int done1, acc2, nonseq2, done2;
    logic [1:0] exp_tr;
    logic exp_dn, exp_rdy;
    a1 = 32'h8000_0200; a2 = 32'h8000_0300; d1 = $urandom(); d2 = $urandom();
    done1 = 3; acc2 = done1 + 1; nonseq2 = acc2 + 1; done2 = nonseq2 + 2;
    @(negedge Hclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_burst = 1'b0; cmd_addr = a1;
    Hreadyout = 1'b1; Hresp = 2'b00;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge Hclk);
      if (cyc == 1) cmd_addr = a2;
      if (cyc == acc2 + 1) cmd_valid = 1'b0;
      Hrdata = (cyc <= done1) ? d1 : d2;
      exp_tr  = (cyc == 1 || cyc == nonseq2) ? 2'b10 : 2'b00;
      exp_dn  = (cyc == done1 || cyc == done2);
      exp_rdy = (cyc == acc2 || cyc > done2);
      n_checks++;
      if (Htrans !== exp_tr || done !== exp_dn || cmd_ready !== exp_rdy ||
          (exp_tr == 2'b10 && Haddr !== ((cyc == 1) ? a1 : a2))) begin
        n_fail++; $display("FAIL b2b/cycle%0d: got trans=%b addr=%h done=%b ready=%b expected trans=%b done=%b ready=%b",
                           cyc, Htrans, Haddr, done, cmd_ready, exp_tr, exp_dn, exp_rdy);
      end
      if (exp_dn) begin
        n_checks++;
        if (rd_valid !== 1'b1 || rd_last !== 1'b1 || rd_data !== ((cyc == done1) ? d1 : d2) || err !== 1'b0) begin
          n_fail++; $display("FAIL b2b/rdata%0d: got v=%b last=%b data=%h err=%b expected 1 1 %h 0",
                             cyc, rd_valid, rd_last, rd_data, err, (cyc == done1) ? d1 : d2);
        end
      end
    end
  endtask

  task automatic test_random();
    int dc, nb, sel, eb;
    logic [31:0] a;
    logic b;
    for (int n = 0; n < 30; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom();
      else if (sel == 1) a = LO - 32'(4 * $urandom_range(1, 8));
      else if (sel == 2) a = HI + 32'(4 * $urandom_range(0, 8));
      else               a = LO + ($urandom() % (HI - LO));
      b  = 1'($urandom_range(0, 1));
      nb = b ? 4 : 1;
      eb = ($urandom_range(0, 4) == 0) ? $urandom_range(1, nb) : 0;
      run_cmd("random", 1'($urandom_range(0, 1)), b, a,
              {$urandom(), $urandom(), $urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()},
              16'($urandom()) & 16'h3333, $urandom_range(0, 2), eb, dc);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_incr4_read_waits();
    test_error();
    test_boundaries();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
